sid_filter_ctrl: RTL and testbench

Filter configuration controller and sample-rate sequencer for the SID filter datapath. It decodes CPU bus writes to the four SID filter registers ($15–$18) into shadow registers and generates the `clk_en` sample strobe from the system clock. On each strobe it transfers the shadow values into the active configuration outputs, so the filter sees a coherent configuration for a whole sample period. The cutoff frequency is slew-limited per sample to suppress zipper noise.

---
 rtl/sid_filter_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sid_filter_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sid_filter_ctrl.sv
// sid_filter_ctrl
//   Filter configuration controller and sample-rate sequencer for the SID
//   filter datapath. CPU writes to $15..$18 land in shadow/target registers.
//   Once every CLK_DIV clocks the clk_en strobe fires, and the shadow values
//   move into the active outputs at that edge, so the filter sees one
//   coherent configuration for each sample. The active cutoff moves toward
//   its target by at most FC_SLEW LSBs per strobe. FC_SLEW = 0 removes the
//   limit.
//
// Ports
//   clk, n_reset          system clock, asynchronous active-low reset
//   wr_en, addr, wdata    bus write (one cycle per write, always accepted)
//   clk_en                registered sample strobe, 1 clk every CLK_DIV clks
//   reg_fc                active cutoff (11 bit)
//   reg_res, reg_en       active resonance / routing {ext, v3, v2, v1}
//   reg_off3/hp/bp/lp     active mode bits
//   reg_vol               active master volume
//   cfg_pending           any active field differs from its shadow/target
module sid_filter_ctrl #(
    parameter int unsigned CLK_DIV = 32,
    parameter int unsigned FC_SLEW = 16
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        wr_en,
    input  logic [4:0]  addr,
    input  logic [7:0]  wdata,
    output logic        clk_en,
    output logic [10:0] reg_fc,
    output logic [3:0]  reg_res,
    output logic [3:0]  reg_en,
    output logic        reg_off3,
    output logic        reg_hp,
    output logic        reg_bp,
    output logic        reg_lp,
    output logic [3:0]  reg_vol,
    output logic        cfg_pending
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    // A limit at or above full scale behaves like no limit at all.
    localparam logic [10:0] SLEW_LIM = (FC_SLEW > 2047) ? 11'd2047 : 11'(FC_SLEW);

    localparam logic [4:0] A_FC_LO    = 5'h15;
    localparam logic [4:0] A_FC_HI    = 5'h16;
    localparam logic [4:0] A_RES_FILT = 5'h17;
    localparam logic [4:0] A_MODE_VOL = 5'h18;

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic          clk_en_q, clk_en_d;

    logic [10:0] fc_tgt_q, fc_tgt_d;
    logic [3:0]  res_sh_q, res_sh_d;
    logic [3:0]  en_sh_q, en_sh_d;
    logic [3:0]  mode_sh_q, mode_sh_d;   // {off3, hp, bp, lp}
    logic [3:0]  vol_sh_q, vol_sh_d;

    logic [10:0] reg_fc_q, reg_fc_d;
    logic [3:0]  reg_res_q, reg_res_d;
    logic [3:0]  reg_en_q, reg_en_d;
    logic [3:0]  reg_mode_q, reg_mode_d;
    logic [3:0]  reg_vol_q, reg_vol_d;

    logic [10:0] fc_gap;
    logic [10:0] fc_step;

    // Divider. clk_en_d looks ahead at the next count, so the flopped
    // strobe is high exactly while div_cnt_q sits at CLK_DIV-1.
    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
        clk_en_d  = (div_cnt_d == DIV_LAST);
    end

    // Register decode into shadow/target.
    always_comb begin
        fc_tgt_d  = fc_tgt_q;
        res_sh_d  = res_sh_q;
        en_sh_d   = en_sh_q;
        mode_sh_d = mode_sh_q;
        vol_sh_d  = vol_sh_q;
        if (wr_en) begin
            unique case (addr)
                A_FC_LO:    fc_tgt_d[2:0]  = wdata[2:0];
                A_FC_HI:    fc_tgt_d[10:3] = wdata;
                A_RES_FILT: begin
                    res_sh_d = wdata[7:4];
                    en_sh_d  = wdata[3:0];
                end
                A_MODE_VOL: begin
                    mode_sh_d = wdata[7:4];
                    vol_sh_d  = wdata[3:0];
                end
                default: ;
            endcase
        end
    end

    // Cutoff slew. The difference is always taken larger-minus-smaller, so
    // it cannot wrap and the step never overshoots the target.
    always_comb begin
        fc_gap  = (fc_tgt_q > reg_fc_q) ? fc_tgt_q - reg_fc_q : reg_fc_q - fc_tgt_q;
        fc_step = (FC_SLEW == 0 || fc_gap <= SLEW_LIM) ? fc_gap : SLEW_LIM;
    end

    // Transfer into the active set on the tick edge; the pre-write shadow
    // is what gets loaded when a write coincides with the tick.
    always_comb begin
        reg_fc_d   = reg_fc_q;
        reg_res_d  = reg_res_q;
        reg_en_d   = reg_en_q;
        reg_mode_d = reg_mode_q;
        reg_vol_d  = reg_vol_q;
        if (clk_en_q) begin
            reg_res_d  = res_sh_q;
            reg_en_d   = en_sh_q;
            reg_mode_d = mode_sh_q;
            reg_vol_d  = vol_sh_q;
            if (fc_tgt_q > reg_fc_q)
                reg_fc_d = reg_fc_q + fc_step;
            else
                reg_fc_d = reg_fc_q - fc_step;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            div_cnt_q  <= '0;
            clk_en_q   <= 1'b0;
            fc_tgt_q   <= '0;
            res_sh_q   <= '0;
            en_sh_q    <= '0;
            mode_sh_q  <= '0;
            vol_sh_q   <= '0;
            reg_fc_q   <= '0;
            reg_res_q  <= '0;
            reg_en_q   <= '0;
            reg_mode_q <= '0;
            reg_vol_q  <= '0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            clk_en_q   <= clk_en_d;
            fc_tgt_q   <= fc_tgt_d;
            res_sh_q   <= res_sh_d;
            en_sh_q    <= en_sh_d;
            mode_sh_q  <= mode_sh_d;
            vol_sh_q   <= vol_sh_d;
            reg_fc_q   <= reg_fc_d;
            reg_res_q  <= reg_res_d;
            reg_en_q   <= reg_en_d;
            reg_mode_q <= reg_mode_d;
            reg_vol_q  <= reg_vol_d;
        end
    end

    assign clk_en   = clk_en_q;
    assign reg_fc   = reg_fc_q;
    assign reg_res  = reg_res_q;
    assign reg_en   = reg_en_q;
    assign reg_off3 = reg_mode_q[3];
    assign reg_hp   = reg_mode_q[2];
    assign reg_bp   = reg_mode_q[1];
    assign reg_lp   = reg_mode_q[0];
    assign reg_vol  = reg_vol_q;

    assign cfg_pending = (reg_fc_q != fc_tgt_q) || (reg_res_q != res_sh_q) ||
                         (reg_en_q != en_sh_q) || (reg_mode_q != mode_sh_q) ||
                         (reg_vol_q != vol_sh_q);

endmodule

// File: tb/tb_sid_filter_ctrl.sv
// Testbench for sid_filter_ctrl: two instances with CLK_DIV = 4 (FC_SLEW = 16
// and FC_SLEW = 0) share one bus. A behavioural model tracks the expected
// outputs, and every negedge compares both instances against it. Directed
// literal checks pin the model's key values.
module tb_sid_filter_ctrl;

    localparam int CD = 4;
    localparam int SLEW [2] = '{16, 0};

    logic        clk = 1'b0;
    logic        n_reset;
    logic        wr_en;
    logic [4:0]  addr;
    logic [7:0]  wdata;

    logic        clk_en   [2];
    logic [10:0] reg_fc   [2];
    logic [3:0]  reg_res  [2];
    logic [3:0]  reg_en   [2];
    logic        reg_off3 [2];
    logic        reg_hp   [2];
    logic        reg_bp   [2];
    logic        reg_lp   [2];
    logic [3:0]  reg_vol  [2];
    logic        cfg_pend [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sid_filter_ctrl #(.CLK_DIV(CD), .FC_SLEW(16)) u_slew (
        .clk(clk), .n_reset(n_reset), .wr_en(wr_en), .addr(addr), .wdata(wdata),
        .clk_en(clk_en[0]), .reg_fc(reg_fc[0]), .reg_res(reg_res[0]), .reg_en(reg_en[0]),
        .reg_off3(reg_off3[0]), .reg_hp(reg_hp[0]), .reg_bp(reg_bp[0]), .reg_lp(reg_lp[0]),
        .reg_vol(reg_vol[0]), .cfg_pending(cfg_pend[0]));

    sid_filter_ctrl #(.CLK_DIV(CD), .FC_SLEW(0)) u_jump (
        .clk(clk), .n_reset(n_reset), .wr_en(wr_en), .addr(addr), .wdata(wdata),
        .clk_en(clk_en[1]), .reg_fc(reg_fc[1]), .reg_res(reg_res[1]), .reg_en(reg_en[1]),
        .reg_off3(reg_off3[1]), .reg_hp(reg_hp[1]), .reg_bp(reg_bp[1]), .reg_lp(reg_lp[1]),
        .reg_vol(reg_vol[1]), .cfg_pending(cfg_pend[1]));

    // ---------------- behavioural model ----------------
    int ecnt;                     // rising edges since reset, modulo CD
    int tgt, res_s, en_s, mode_s, vol_s;
    int a_res, a_en, a_mode, a_vol;
    int m_fc [2];
    logic m_clk_en;
    assign m_clk_en = (ecnt == CD - 1);

    function automatic int slew_to(int cur, int t, int lim);
        int d = t - cur;
        if (lim == 0) return t;
        if (d > 0) return cur + ((d < lim) ? d : lim);
        return cur - ((-d < lim) ? -d : lim);
    endfunction

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ecnt = 0; tgt = 0; res_s = 0; en_s = 0; mode_s = 0; vol_s = 0;
            a_res = 0; a_en = 0; a_mode = 0; a_vol = 0;
            m_fc[0] = 0; m_fc[1] = 0;
        end else begin
            if (m_clk_en) begin
                a_res = res_s; a_en = en_s; a_mode = mode_s; a_vol = vol_s;
                for (int i = 0; i < 2; i++) m_fc[i] = slew_to(m_fc[i], tgt, SLEW[i]);
            end
            if (wr_en) begin
                case (int'(addr))
                    'h15: tgt = (tgt / 8) * 8 + (int'(wdata) % 8);
                    'h16: tgt = int'(wdata) * 8 + (tgt % 8);
                    'h17: begin res_s = int'(wdata) / 16; en_s = int'(wdata) % 16; end
                    'h18: begin mode_s = int'(wdata) / 16; vol_s = int'(wdata) % 16; end
                    default: ;
                endcase
            end
            ecnt = (ecnt + 1) % CD;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int pend;
            pend = (m_fc[i] != tgt || a_res != res_s || a_en != en_s ||
                    a_mode != mode_s || a_vol != vol_s) ? 1 : 0;
            chk($sformatf("u%0d.clk_en", i), int'(clk_en[i]), int'(m_clk_en));
            chk($sformatf("u%0d.reg_fc", i), int'(reg_fc[i]), m_fc[i]);
            chk($sformatf("u%0d.res_en", i), int'({reg_res[i], reg_en[i]}), a_res * 16 + a_en);
            chk($sformatf("u%0d.mode_vol", i),
                int'({reg_off3[i], reg_hp[i], reg_bp[i], reg_lp[i], reg_vol[i]}),
                a_mode * 16 + a_vol);
            chk($sformatf("u%0d.cfg_pending", i), int'(cfg_pend[i]), pend);
        end
    end

    // ---------------- stimulus helpers (all aligned to posedge + 1) ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        cyc(1);
        wr_en = 1'b0;
    endtask

    // Advance until the current cycle is a clk_en cycle (bounded).
    task automatic to_tick();
        int n = 0;
        while (!m_clk_en && n < 4 * CD) begin
            cyc(1);
            n++;
        end
        if (!m_clk_en) begin
            tests++; fails++;
            $display("FAIL to_tick: no strobe within %0d cycles", 4 * CD);
        end
    endtask

    task automatic after_tick();
        to_tick();
        cyc(1);
    endtask

    initial begin
        n_reset = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
        cyc(3);
        chk("rst.outputs", int'({clk_en[0], reg_fc[0], reg_res[0], reg_vol[0], cfg_pend[0]}), 0);
        n_reset = 1'b1;

        // Divider: strobe after the 3rd edge, then every 4 clocks, 1 clk wide.
        cyc(2); chk("div.pre", int'(clk_en[0]), 0);
        cyc(1); chk("div.first", int'(clk_en[0]), 1);
        cyc(1); chk("div.width", int'(clk_en[0]), 0);
        cyc(3); chk("div.second", int'(clk_en[0]), 1);

        // Tick-aligned update.
        cyc(1);
        wr(5'h18, 8'h9F);
        chk("mode.pending", int'(cfg_pend[0]), 1);
        chk("mode.held", int'(reg_vol[0]), 0);
        after_tick();
        chk("mode.bits", int'({reg_off3[0], reg_hp[0], reg_bp[0], reg_lp[0]}), 'b1001);
        chk("mode.vol", int'(reg_vol[0]), 15);
        chk("mode.settled", int'(cfg_pend[0]), 0);
        wr(5'h17, 8'hA5);
        after_tick();
        chk("resfilt.res", int'(reg_res[0]), 'hA);
        chk("resfilt.en", int'(reg_en[0]), 5);

        // Write coincident with the tick.
        to_tick();
        wr(5'h17, 8'h31);
        chk("coinc.old_res", int'(reg_res[0]), 'hA);
        chk("coinc.old_en", int'(reg_en[0]), 5);
        after_tick();
        chk("coinc.new", int'({reg_res[0], reg_en[0]}), 'h31);

        // Ignored addresses and overwrite.
        wr(5'h14, 8'hFF);
        wr(5'h19, 8'hFF);
        chk("ignored.pending", int'(cfg_pend[0]), 0);
        after_tick();
        wr(5'h18, 8'h01);
        wr(5'h18, 8'h02);
        after_tick();
        chk("overwrite.vol", int'(reg_vol[0]), 2);

        // Cutoff slew up to 0x7FF.
        after_tick();
        wr(5'h15, 8'hFF);
        wr(5'h16, 8'hFF);
        for (int k = 1; k <= 128; k++) begin
            after_tick();
            chk("slew.up", int'(reg_fc[0]), (k < 128) ? 16 * k : 2047);
            if (k == 1) begin
                chk("jump.up", int'(reg_fc[1]), 2047);
                chk("model.step1", m_fc[0], 16);
            end
        end
        chk("slew.settled", int'(cfg_pend[0]), 0);

        // Ramp down toward 0.
        wr(5'h15, 8'h00);
        wr(5'h16, 8'h00);
        for (int k = 1; k <= 3; k++) begin
            after_tick();
            chk("slew.down", int'(reg_fc[0]), 2047 - 16 * k);
        end
        chk("jump.down", int'(reg_fc[1]), 0);

        // Reset mid-slew.
        n_reset = 1'b0; cyc(1); n_reset = 1'b1;
        after_tick();
        wr(5'h15, 8'hFF);
        wr(5'h16, 8'hFF);
        for (int k = 0; k < 64; k++) after_tick();
        chk("midslew.fc", int'(reg_fc[0]), 'h400);
        #3 n_reset = 1'b0;
        #1 chk("midslew.async", int'({reg_fc[0], reg_fc[1], clk_en[0], cfg_pend[0]}), 0);
        cyc(2);
        n_reset = 1'b1;
        for (int k = 0; k < 5 * CD; k++) begin
            cyc(1);
            chk("postrst.fc", int'(reg_fc[0]), 0);
        end

        // Randomised traffic, checked cycle by cycle against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(2) == 0) begin
                wr_en = 1'b1;
                addr  = 5'(5'h13 + $urandom_range(7));
                wdata = 8'($urandom);
            end else begin
                wr_en = 1'b0;
            end
            cyc(1);
        end
        wr_en = 1'b0;
        cyc(4 * CD);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
